// File: rtl/jt12_kon_wr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : jt12_kon_wr_pkg                                        |
// | Description : Shared constants, types and helpers for the key-on     |
// |               register writer (register 0x28, part 0).               |
// |               No ports: package only.                                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package jt12_kon_wr_pkg;

   // Key-on register address inside part 0
   localparam logic [7:0] KON_REG_ADDR = 8'h28;

   // Queue entry width: {ch[2:0], op[3:0]}
   localparam int KON_ENTRY_W = 7;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } kon_state_t;

   typedef struct packed {
      logic [2:0] ch;
      logic [3:0] op;
   } kon_entry_t;

   // One full operator-slot cycle: four operators per channel
   function automatic int kon_slots(input int num_ch);
      return num_ch * 4;
   endfunction

   // Channel codes skip 3 and 7; the upper group (4..6) exists only
   // on the six-channel variant.
   function automatic logic kon_code_valid(input logic [2:0] code, input int num_ch);
      logic ok;
      case (code)
         3'd0, 3'd1, 3'd2: ok = 1'b1;
         3'd4, 3'd5, 3'd6: ok = (num_ch > 3);
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage
`default_nettype wire

// File: rtl/jt12_kon_wr_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : jt12_kon_fifo                                          |
// | Description : Small synchronous FIFO for pending key-on writes.      |
// |               A push on a full queue is accepted when a pop happens  |
// |               on the same edge.                                      |
// | Ports       : clk, rst (sync, active-high), push, pop, din[DW-1:0],  |
// |               dout[DW-1:0] (head, combinational), empty, full        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module jt12_kon_fifo #(
   parameter int DW    = 7,
   parameter int DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          empty,
   output logic          full
);

   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNTW = $clog2(DEPTH + 1);

   logic [DW-1:0]   r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CNTW-1:0] r_count;
   logic            w_do_pop;
   logic            w_do_push;

   function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty     = (r_count == '0);
   assign full      = (r_count == CNTW'(DEPTH));
   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & (~full | w_do_pop);
   assign dout      = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= ptr_next(r_wr_ptr);
         if (w_do_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/jt12_kon_wr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : jt12_kon_wr                                            |
// | Description : CPU-side key-on register writer. Decodes writes to     |
// |               0x28 (part 0), queues them, and presents each entry to |
// |               the key-on consumer for one full operator-slot cycle.  |
// | Ports       : clk, rst (sync, active-high), clk_en (slot strobe),    |
// |               write, addr[1:0] {a1,a0}, din[7:0] -> keyon_op[3:0],   |
// |               keyon_ch[2:0], up_keyon, busy, kon_drop (sticky)       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module jt12_kon_wr
   import jt12_kon_wr_pkg::*;
#(
   parameter int NUM_CH  = 6,
   parameter int FIFO_DW = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_en,
   input  logic       write,
   input  logic [1:0] addr,
   input  logic [7:0] din,
   output logic [3:0] keyon_op,
   output logic [2:0] keyon_ch,
   output logic       up_keyon,
   output logic       busy,
   output logic       kon_drop
);

   localparam int SLOTS = kon_slots(NUM_CH);
   localparam int CW    = $clog2(SLOTS);

   kon_state_t       r_state;
   logic [7:0]       r_addr;
   logic             r_part;
   logic [CW-1:0]    r_cnt;

   logic             w_kon_wr;
   logic             w_pop;
   logic             w_empty;
   logic             w_full;
   logic             w_drop;
   kon_entry_t       w_new;
   logic [KON_ENTRY_W-1:0] w_head_raw;
   kon_entry_t       w_head;
   logic             w_unused;

   assign w_unused = din[3];

   assign w_kon_wr = write & addr[0] & ~r_part & (r_addr == KON_REG_ADDR)
                   & kon_code_valid(din[2:0], NUM_CH);
   assign w_new    = '{ch: din[2:0], op: din[7:4]};
   assign w_pop    = (r_state == ST_IDLE) & ~w_empty;
   // A full queue still takes the write if the head leaves on this edge
   assign w_drop   = w_kon_wr & w_full & ~w_pop;
   assign w_head   = kon_entry_t'(w_head_raw);
   assign busy     = up_keyon | ~w_empty;

   jt12_kon_fifo #(
      .DW    (KON_ENTRY_W),
      .DEPTH (FIFO_DW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_kon_wr),
      .pop   (w_pop),
      .din   (w_new),
      .dout  (w_head_raw),
      .empty (w_empty),
      .full  (w_full)
   );

   // Address/part latch and sticky drop flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr   <= '0;
         r_part   <= 1'b0;
         kon_drop <= 1'b0;
      end else begin
         if (write & ~addr[0]) begin
            r_addr <= din;
            r_part <= addr[1];
         end
         if (w_drop) kon_drop <= 1'b1;
      end
   end

   // Presentation FSM; keyon_ch/keyon_op keep their value after a hold
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         up_keyon <= 1'b0;
         keyon_ch <= '0;
         keyon_op <= '0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!w_empty) begin
                  keyon_ch <= w_head.ch;
                  keyon_op <= w_head.op;
                  up_keyon <= 1'b1;
                  r_cnt    <= CW'(SLOTS - 1);
                  r_state  <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (clk_en) begin
                  if (r_cnt == '0) begin
                     up_keyon <= 1'b0;
                     r_state  <= ST_IDLE;
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
            end
            default: begin
               up_keyon <= 1'b0;
               r_state  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_jt12_kon_wr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_jt12_kon_wr                                         |
// | Description : Directed self-checking bench for jt12_kon_wr, with a   |
// |               six-channel and a three-channel instance on shared     |
// |               inputs.                                                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_jt12_kon_wr;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clk_en = 1'b1;
   logic       write = 1'b0;
   logic [1:0] addr = 2'b00;
   logic [7:0] din = 8'h00;

   logic [3:0] op6, op3;
   logic [2:0] ch6, ch3;
   logic       up6, up3, busy6, busy3, drop6, drop3;

   int n_checks = 0;
   int n_errors = 0;

   jt12_kon_wr #(.NUM_CH(6), .FIFO_DW(2)) u_dut6 (
      .clk(clk), .rst(rst), .clk_en(clk_en), .write(write), .addr(addr), .din(din),
      .keyon_op(op6), .keyon_ch(ch6), .up_keyon(up6), .busy(busy6), .kon_drop(drop6)
   );

   jt12_kon_wr #(.NUM_CH(3), .FIFO_DW(2)) u_dut3 (
      .clk(clk), .rst(rst), .clk_en(clk_en), .write(write), .addr(addr), .din(din),
      .keyon_op(op3), .keyon_ch(ch3), .up_keyon(up3), .busy(busy3), .kon_drop(drop3)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs driven and outputs sampled 1 ns after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      write = 1'b1;
      addr  = a;
      din   = d;
      tick();
      write = 1'b0;
   endtask

   // Called with up_keyon currently high; returns the number of samples it stayed high
   task automatic hold_len(input bit sel3, output int n);
      n = 0;
      while ((sel3 ? up3 : up6) && n < 200) begin
         n++;
         tick();
      end
   endtask

   int n;

   initial begin
      // Reset state
      do_reset();
      check("rst_up", up6, 0);
      check("rst_busy", busy6, 0);
      check("rst_drop", drop6, 0);
      check("rst_ch_op", {ch6, op6}, 0);

      // 1: basic key-on, 24-tick hold
      wr(2'b00, 8'h28);
      wr(2'b01, 8'hF1);
      check("t1_up_early", up6, 0);
      check("t1_busy_q", busy6, 1);
      tick();
      check("t1_up", up6, 1);
      check("t1_ch", ch6, 3'd1);
      check("t1_op", op6, 4'hF);
      hold_len(0, n);
      check("t1_len", n, 24);
      check("t1_busy_end", busy6, 0);
      check("t1_ch_kept", ch6, 3'd1);

      // 2: invalid channel codes
      do_reset();
      wr(2'b00, 8'h28);
      wr(2'b01, 8'h13);
      check("t2_busy_a", busy6, 0);
      wr(2'b01, 8'h77);
      tick();
      check("t2_up", up6, 0);
      check("t2_busy_b", busy6, 0);
      check("t2_drop", drop6, 0);

      // 3: queueing, drop on full, ordering, one low clk between holds
      do_reset();
      wr(2'b00, 8'h28);
      write = 1'b1; addr = 2'b01;
      din = 8'h10; tick();
      din = 8'h21; tick();
      din = 8'h42; tick();
      write = 1'b0;
      check("t3_up", up6, 1);
      check("t3_e1", {ch6, op6}, {3'd0, 4'h1});
      check("t3_nodrop", drop6, 0);
      wr(2'b01, 8'h84);
      check("t3_drop", drop6, 1);
      hold_len(0, n);
      check("t3_len1", n, 22);   // two samples already consumed above
      check("t3_gap1", up6, 0);
      tick();
      check("t3_up2", up6, 1);
      check("t3_e2", {ch6, op6}, {3'd1, 4'h2});
      hold_len(0, n);
      check("t3_len2", n, 24);
      check("t3_gap2", up6, 0);
      tick();
      check("t3_up3", up6, 1);
      check("t3_e3", {ch6, op6}, {3'd2, 4'h4});
      hold_len(0, n);
      check("t3_len3", n, 24);
      tick();
      check("t3_no4th", up6, 0);
      check("t3_busy_end", busy6, 0);
      check("t3_drop_sticky", drop6, 1);

      // 4: part 1 and other addresses are ignored
      do_reset();
      wr(2'b10, 8'h28);
      wr(2'b11, 8'hF1);
      wr(2'b01, 8'hF1);
      tick();
      check("t4_part1", busy6, 0);
      wr(2'b00, 8'h27);
      wr(2'b01, 8'hF1);
      tick();
      check("t4_addr27", busy6, 0);

      // 5: three-channel variant
      do_reset();
      wr(2'b00, 8'h28);
      wr(2'b01, 8'hF4);
      tick();
      check("t5_ign", busy3, 0);
      check("t5_ign_drop", drop3, 0);
      do_reset();
      wr(2'b00, 8'h28);
      wr(2'b01, 8'hF2);
      tick();
      check("t5_up", up3, 1);
      check("t5_e", {ch3, op3}, {3'd2, 4'hF});
      hold_len(1, n);
      check("t5_len", n, 12);

      // 6: reset mid-hold with a non-empty queue
      do_reset();
      wr(2'b00, 8'h28);
      write = 1'b1; addr = 2'b01;
      din = 8'h10; tick();
      din = 8'h21; tick();
      din = 8'h42; tick();
      din = 8'h84; tick();
      write = 1'b0;
      check("t6_pre_drop", drop6, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_up", up6, 0);
      check("t6_busy", busy6, 0);
      check("t6_drop", drop6, 0);
      tick();
      check("t6_stay_idle", busy6, 0);
      wr(2'b00, 8'h28);
      wr(2'b01, 8'hF1);
      check("t6_up_early", up6, 0);
      tick();
      check("t6_e", {up6, ch6, op6}, {1'b1, 3'd1, 4'hF});
      hold_len(0, n);
      check("t6_len", n, 24);

      // 7: clk_en low freezes the hold
      do_reset();
      wr(2'b00, 8'h28);
      wr(2'b01, 8'h26);
      clk_en = 1'b0;
      tick();
      check("t7_e", {up6, ch6, op6}, {1'b1, 3'd6, 4'h2});
      repeat (40) tick();
      check("t7_frozen", up6, 1);
      clk_en = 1'b1;
      hold_len(0, n);
      check("t7_len", n, 24);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
